// File: rtl/counter_updown_mod_if.sv
// counter_updown_mod_if: control inputs and count outputs of counter_updown_mod
interface counter_updown_mod_if #(parameter int WIDTH = 8);
  logic en, up, clear, load;
  logic [WIDTH-1:0] load_val, value;
  logic tc, ovf;
  modport master (output en, up, clear, load, load_val, input value, tc, ovf);
  modport slave (input en, up, clear, load, load_val, output value, tc, ovf);
endinterface

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: up/down modulo counter with wrap/saturate, tc pulse and sticky ovf
// optional prescaler enabled by COUNTER_PRESCALE_EN
module counter_updown_mod #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter bit SATURATE = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef COUNTER_PRESCALE_EN
  , parameter int PRESCALE = 4
`endif
) (
  input logic clk,
  input logic reset,
  counter_updown_mod_if.slave b
);
  logic step, at_lim, tc_n, ovf_n;
  logic [WIDTH-1:0] value_n;
`ifdef COUNTER_PRESCALE_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre, pre_n;
  always_comb begin
    step = b.en && pre == PW'(PRESCALE - 1);
    pre_n = (b.clear || b.load) ? '0 : b.en ? (step ? '0 : pre + PW'(1)) : pre;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pre <= '0;
    else pre <= pre_n;
`else
  always_comb step = b.en;
`endif
  always_comb begin
    at_lim = b.up ? b.value == MAX_VAL : b.value == '0;
    value_n = b.clear ? '0 :
              b.load ? (b.load_val > MAX_VAL ? MAX_VAL : b.load_val) :
              !step ? b.value :
              at_lim ? (SATURATE ? b.value : (b.up ? '0 : MAX_VAL)) :
              b.up ? b.value + WIDTH'(1) : b.value - WIDTH'(1);
    tc_n = !b.clear && !b.load && step && at_lim;
    ovf_n = !b.clear && (b.ovf || tc_n);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      b.value <= RESET_VAL;
      b.tc <= 1'b0;
      b.ovf <= 1'b0;
    end else begin
      b.value <= value_n;
      b.tc <= tc_n;
      b.ovf <= ovf_n;
    end
endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod: directed vectors against several counter configurations plus a spec-level model
module tb_counter_updown_mod;
  localparam int ND = `ifdef COUNTER_PRESCALE_EN 4 `else 3 `endif ;
  localparam int MX [4] = '{255, 9, 9, 255};
  localparam bit SAT [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam int RV [4] = '{0, 3, 0, 0};
  localparam int PS [4] = '{1, 1, 1, 4};
  typedef struct {int v; int p; bit t; bit o;} st_t;
  logic clk = 0, reset = 0, en = 0, up = 0, clear = 0, load = 0, run = 0;
  logic [7:0] lv = '0;
  logic [7:0] dv [ND];
  logic dt [ND], dov [ND];
  st_t m [ND];
  int vec = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < ND; g++) begin : gd
    counter_updown_mod_if #(.WIDTH(8)) b();
    assign b.en = en;
    assign b.up = up;
    assign b.clear = clear;
    assign b.load = load;
    assign b.load_val = lv;
    assign dv[g] = b.value;
    assign dt[g] = b.tc;
    assign dov[g] = b.ovf;
    counter_updown_mod #(.WIDTH(8), .MAX_VAL(8'(MX[g])), .SATURATE(SAT[g]), .RESET_VAL(8'(RV[g]))
`ifdef COUNTER_PRESCALE_EN
      , .PRESCALE(PS[g])
`endif
    ) u (.clk(clk), .reset(reset), .b(b.slave));
  end
  function automatic st_t nxt(int i, st_t s);
    st_t r = s;
    bit lim;
    r.t = 1'b0;
    if (clear) r = '{default: 0};
    else if (load) begin
      r.v = int'(lv) > MX[i] ? MX[i] : int'(lv);
      r.p = 0;
    end else if (en) begin
      if (s.p == PS[i] - 1) begin
        r.p = 0;
        lim = up ? s.v == MX[i] : s.v == 0;
        if (lim) begin
          r.t = 1'b1;
          r.o = 1'b1;
          if (!SAT[i]) r.v = up ? 0 : MX[i];
        end else r.v = up ? s.v + 1 : s.v - 1;
      end else r.p = s.p + 1;
    end
    return r;
  endfunction
  always @(posedge clk or negedge reset)
    for (int i = 0; i < ND; i++)
      if (!reset) m[i] <= '{v: RV[i], p: 0, t: 1'b0, o: 1'b0};
      else m[i] <= nxt(i, m[i]);
  task automatic chk(string n, int a, int e);
    vec++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  always @(negedge clk)
    if (run)
      for (int i = 0; i < ND; i++) begin
        chk($sformatf("model_value%0d", i), int'(dv[i]), m[i].v);
        chk($sformatf("model_tc%0d", i), int'(dt[i]), int'(m[i].t));
        chk($sformatf("model_ovf%0d", i), int'(dov[i]), int'(m[i].o));
      end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_value0", int'(dv[0]), 0);
    chk("rst_value1", int'(dv[1]), 3);
    chk("rst_tc0", int'(dt[0]), 0);
    chk("rst_ovf1", int'(dov[1]), 0);
    run = 1;
    reset = 1;
    en = 1;
    up = 1;
    for (int k = 1; k <= 260; k++) begin
      @(negedge clk);
      if (k == 255) begin
        chk("up_ff", int'(dv[0]), 255);
        chk("up_ff_tc", int'(dt[0]), 0);
        chk("up_ff_ovf", int'(dov[0]), 0);
      end
      if (k == 256) begin
        chk("wrap_value", int'(dv[0]), 0);
        chk("wrap_tc", int'(dt[0]), 1);
        chk("wrap_ovf", int'(dov[0]), 1);
      end
      if (k == 257) begin
        chk("post_wrap_value", int'(dv[0]), 1);
        chk("post_wrap_tc", int'(dt[0]), 0);
        chk("post_wrap_ovf", int'(dov[0]), 1);
      end
    end
    en = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    en = 1;
    up = 0;
    @(negedge clk);
    chk("down_wrap_value", int'(dv[1]), 9);
    chk("down_wrap_tc", int'(dt[1]), 1);
    chk("down_wrap_ovf", int'(dov[1]), 1);
    chk("down_sat_value", int'(dv[2]), 0);
    chk("down_sat_tc", int'(dt[2]), 1);
    @(negedge clk);
    chk("down_8", int'(dv[1]), 8);
    chk("down_8_tc", int'(dt[1]), 0);
    @(negedge clk);
    chk("down_7", int'(dv[1]), 7);
    en = 0;
    clear = 1;
    @(negedge clk);
    clear = 0;
    load = 1;
    lv = 8;
    @(negedge clk);
    chk("sat_load", int'(dv[2]), 8);
    load = 0;
    en = 1;
    up = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("sat_value%0d", k), int'(dv[2]), 9);
      chk($sformatf("sat_tc%0d", k), int'(dt[2]), k > 0 ? 1 : 0);
      chk($sformatf("sat_ovf%0d", k), int'(dov[2]), k > 0 ? 1 : 0);
    end
    clear = 1;
    load = 1;
    lv = 5;
    @(negedge clk);
    chk("prio_value", int'(dv[2]), 0);
    chk("prio_tc", int'(dt[2]), 0);
    chk("prio_ovf", int'(dov[2]), 0);
    clear = 0;
    en = 0;
    lv = 200;
    @(negedge clk);
    chk("clamp_value", int'(dv[1]), 9);
    chk("noclamp_value", int'(dv[0]), 200);
    lv = 0;
    @(negedge clk);
    load = 0;
    en = 1;
    up = 0;
    @(negedge clk);
    chk("under_value", int'(dv[0]), 255);
    chk("under_ovf", int'(dov[0]), 1);
    en = 0;
    load = 1;
    lv = 8'h37;
    @(negedge clk);
    chk("load37_value", int'(dv[0]), 8'h37);
    chk("load_keeps_ovf", int'(dov[0]), 1);
    load = 0;
    #2 reset = 0;
    #1;
    chk("async_value0", int'(dv[0]), 0);
    chk("async_value1", int'(dv[1]), 3);
    chk("async_ovf", int'(dov[0]), 0);
    @(negedge clk);
    reset = 1;
    en = 1;
    up = 1;
    @(negedge clk);
    chk("fresh_value0", int'(dv[0]), 1);
    chk("fresh_value1", int'(dv[1]), 4);
    en = 0;
    clear = 1;
    @(negedge clk);
    en = 1;
    for (int k = 1; k <= 12; k++) begin
      clear = k == 6;
      @(negedge clk);
`ifdef COUNTER_PRESCALE_EN
      if (k == 3) chk("pre_c3", int'(dv[3]), 0);
      if (k == 4) chk("pre_c4", int'(dv[3]), 1);
      if (k == 6) chk("pre_c6", int'(dv[3]), 0);
      if (k == 9) chk("pre_c9", int'(dv[3]), 0);
      if (k == 10) chk("pre_c10", int'(dv[3]), 1);
`endif
    end
    clear = 0;
    en = 0;
    @(negedge clk);
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
- Parametrised successor to the team's free-running 8-bit counter.
- Adds configurable width and modulus, up/down direction, count enable, synchronous clear and parallel load.
- Adds a wrap-or-saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used as a general event/timer counter in example designs and as a building block for dividers and timeouts.

Parameters:
- WIDTH, 8, counter width in bits; legal range 2..32.
- MAX_VAL, 2**WIDTH-1, upper count limit; count range is 0..MAX_VAL; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.
- RESET_VAL, 0, value loaded by asynchronous reset; must be <= MAX_VAL.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous reset, active-low; assertion takes effect immediately, deassertion is synchronised externally.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction; 1 = increment, 0 = decrement.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value applied by load.
- value  output  WIDTH  current count (registered).
- tc  output  1  terminal-count pulse (registered).
- ovf  output  1  sticky overflow/underflow flag (registered).

Behaviour:
- Reset (reset=0, asynchronous): value=RESET_VAL, tc=0, ovf=0. Reset mid-count aborts the count immediately; the first edge after release behaves as from a fresh state.
- Per-edge priority: clear > load > en. Inputs of lower priority are ignored in that cycle.
- Clear: value<=0, tc<=0, ovf<=0.
- Load:
  - value <= min(load_val, MAX_VAL); out-of-range loads clamp to MAX_VAL.
  - tc<=0; ovf unchanged.
- Count (en=1, no clear, no load):
  - Boundary step: up=1 with value==MAX_VAL, or up=0 with value==0.
  - Non-boundary step: value <= value+1 (up=1) or value-1 (up=0); tc<=0.
  - Boundary step, SATURATE=0: value wraps (MAX_VAL->0 up, 0->MAX_VAL down); tc<=1; ovf<=1.
  - Boundary step, SATURATE=1: value holds; tc<=1 on every such cycle; ovf<=1.
- Idle (en=0, no clear, no load): value holds, tc<=0.
- tc rules:
  - Single-cycle unless consecutive boundary steps occur (saturate hold, or MAX_VAL=1 wrap).
  - tc is high in the same cycle the post-step value is visible.
- ovf: sticky; cleared only by reset or clear.
- Arithmetic: internal compare against MAX_VAL is done at WIDTH bits. For non-power-of-two MAX_VAL, values above MAX_VAL are unreachable.
- Latency: one clock from input sample to value/tc/ovf update. No combinational input-to-output paths.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- When defined:
  - Adds parameter PRESCALE (default 4, >=1) and an internal prescale counter of clog2(PRESCALE) bits, minimum 1 bit.
  - With en=1, the main count steps only on every PRESCALE-th enabled cycle, i.e. when the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - The prescaler increments only while en=1 and holds otherwise.
  - The prescaler resets to 0 on reset, clear or load.
  - tc/ovf follow main-count steps only.
- When not defined: the prescaler logic and the PRESCALE parameter are absent; every enabled cycle is a step.

Test Plan:
- Defaults, reset=0 then 1, en=1, up=1 for 260 clocks -> value counts 00..FF, wraps to 00 at step 256 with tc=1 for exactly that cycle, ovf=1 thereafter.
- MAX_VAL=9, up=0 from value 0 -> next value 9, tc=1, ovf=1; following steps 8,7,... with tc=0.
- SATURATE=1, MAX_VAL=9, load_val=8 loaded, en=1 up=1 for 3 clocks -> value 9,9,9; tc=0,1,1; ovf=0,1,1.
- Same cycle clear=1, load=1 (load_val=5), en=1 -> value=0, tc=0, ovf=0. Next cycle load=1, load_val=200 with MAX_VAL=9 -> value=9.
- Assert reset=0 mid-edge-free interval while value=0x37 -> value=RESET_VAL immediately, before the next clk edge; tc=0, ovf=0.
- With COUNTER_PRESCALE_EN, PRESCALE=4, en=1 up=1 from 0 for 12 clocks -> value steps to 1,2,3 only on clocks 4, 8, 12. A clear on clock 6 restarts the prescaler, so the next step occurs on clock 10.
